// File: rtl/dsg_pkg.sv
// Shared types and sizes for the digital signal generator.
// The sine table builder is only referenced when DSG_SINE_LUT_EN is defined.
package dsg_pkg;

  localparam int PHASE_W   = 16;
  localparam int OUT_W     = 16;
  localparam int AMP_W     = 4;
  localparam int LUT_DEPTH = 256;

  typedef enum logic [1:0] {
    SINE     = 2'b00,
    SQUARE   = 2'b01,
    TRIANGLE = 2'b10,
    SAWTOOTH = 2'b11
  } wave_e;

  // Quarter-wave entry i = round(32767*sin(pi/2 * i/255)); evaluated only at elaboration.
  function automatic logic [14:0] sine_mag(input int i);
    real x;
    real term;
    real sum;
    x    = 1.5707963267948966 * real'(i) / 255.0;
    term = x;
    sum  = x;
    for (int k = 1; k <= 9; k++) begin
      term = -term * x * x / real'((2 * k) * (2 * k + 1));
      sum  = sum + term;
    end
    return 15'($rtoi(sum * 32767.0 + 0.5));
  endfunction

endpackage

// File: rtl/dsg_if.sv
// Control inputs and sample outputs of the generator, bundled as one port.
interface dsg_if;
  logic [1:0]  wavetype;
  logic [2:0]  freqsel;
  logic [3:0]  phaseshift;
  logic [3:0]  amplitude;
  logic [15:0] sout;
  logic        led;

  // No handshake: controls are level inputs, sampled on every rising clock edge.
  modport master (
    output wavetype, freqsel, phaseshift, amplitude,
    input  sout, led
  );

  modport slave (
    input  wavetype, freqsel, phaseshift, amplitude,
    output sout, led
  );
endinterface

// File: rtl/dsg_sine_lut.sv
// Combinational quarter-wave sine magnitude table (8-bit index -> 15-bit magnitude).
module dsg_sine_lut
  import dsg_pkg::*;
(
  input  logic [7:0]  idx,
  output logic [14:0] mag
);

  logic [14:0] table_q [LUT_DEPTH];

  for (genvar g = 0; g < LUT_DEPTH; g++) begin : g_tab
    localparam logic [14:0] MAG = sine_mag(g);
    assign table_q[g] = MAG;
  end

  assign mag = table_q[idx];

endmodule

// File: rtl/digital_signal_generator.sv
// Phase-accumulator waveform generator: sine/square/triangle/sawtooth with gain and phase offset.
// Optional DSG_SINE_LUT_EN compiles in the sine table; without it, sine selects the triangle.
module digital_signal_generator
  import dsg_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  dsg_if.slave  bus
);

  logic [PHASE_W-1:0]      acc;
  logic [PHASE_W-1:0]      inc;
  logic [PHASE_W-1:0]      p;
  logic [14:0]             tri_t;
  logic signed [OUT_W-1:0] w_sq;
  logic signed [OUT_W-1:0] w_saw;
  logic signed [OUT_W-1:0] w_tri;
  logic signed [OUT_W-1:0] w_sine;
  logic signed [OUT_W-1:0] w;
  logic signed [20:0]      prod;
  wave_e                   wave;

  assign wave = wave_e'(bus.wavetype);
  assign inc  = PHASE_W'(1) << bus.freqsel;
  assign p    = acc + {bus.phaseshift, 12'h000};

  assign w_sq  = p[15] ? 16'sh8001 : 16'sh7FFF;
  assign w_saw = {~p[15], p[14:0]};
  assign tri_t = p[15] ? ~p[14:0] : p[14:0];
  // {t,0} - 32768 is the same as flipping the top bit of {t,0}.
  assign w_tri = {~tri_t[14], tri_t[13:0], 1'b0};

`ifdef DSG_SINE_LUT_EN
  logic [7:0]              lut_idx;
  logic [14:0]             mag;
  logic signed [OUT_W-1:0] mag_s;

  assign lut_idx = p[14] ? ~p[13:6] : p[13:6];

  dsg_sine_lut u_sine_lut (
    .idx (lut_idx),
    .mag (mag)
  );

  assign mag_s  = {1'b0, mag};
  assign w_sine = p[15] ? -mag_s : mag_s;
`else
  assign w_sine = w_tri;
`endif

  always_comb begin
    w = w_saw;
    case (wave)
      SINE:     w = w_sine;
      SQUARE:   w = w_sq;
      TRIANGLE: w = w_tri;
      SAWTOOTH: w = w_saw;
      default:  w = w_saw;
    endcase
  end

  // |w*15| < 2^19, so bits [19:4] of the floor-shifted product hold the exact result.
  assign prod = w * $signed({1'b0, bus.amplitude});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= '0;
      bus.sout <= '0;
      bus.led  <= 1'b0;
    end else begin
      acc      <= acc + inc;
      bus.sout <= prod[19:4];
      bus.led  <= (bus.amplitude != '0);
    end
  end

endmodule

// File: tb/tb_digital_signal_generator.sv
// Self-checking bench for digital_signal_generator: arithmetic reference model plus literal checks.
// Define DSG_SINE_LUT_EN on both bench and RTL to exercise the sine table.
module tb_digital_signal_generator;

  logic       clk;
  logic       rst_n;
  logic [1:0] wt;
  logic [2:0] fs;
  logic [3:0] ps;
  logic [3:0] amp;

  int tests;
  int fails;
  int acc_m;

  dsg_if bus ();

  assign bus.wavetype   = wt;
  assign bus.freqsel    = fs;
  assign bus.phaseshift = ps;
  assign bus.amplitude  = amp;

  digital_signal_generator dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic int floor_div16(input int v);
    if (v >= 0) return v / 16;
    return -((-v + 15) / 16);
  endfunction

  function automatic int model_sample(input int acc, input int wtype, input int pshift, input int gain);
    int p;
    int w;
    int t;
    p = (acc + pshift * 4096) % 65536;
    t = (p < 32768) ? p : 65535 - p;
    case (wtype)
      1: w = (p < 32768) ? 32767 : -32767;
      2: w = 2 * t - 32768;
      3: w = p - 32768;
      default: begin
`ifdef DSG_SINE_LUT_EN
        int q;
        int i;
        int m;
        q = p % 16384;
        i = (((p / 16384) % 2) == 1) ? 255 - q / 64 : q / 64;
        m = $rtoi(32767.0 * $sin(1.5707963267948966 * real'(i) / 255.0) + 0.5);
        w = (p >= 32768) ? -m : m;
`else
        w = 2 * t - 32768;
`endif
      end
    endcase
    return floor_div16(w * gain);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge rst_n) acc_m = 0;

  // ---------------- compare process (scoreboard) ----------------
  always @(posedge clk) begin
    int exp_s;
    int exp_l;
    if (rst_n) begin
      exp_s = model_sample(acc_m, int'(wt), int'(ps), int'(amp));
      exp_l = (amp != 0) ? 1 : 0;
      acc_m = (acc_m + (1 << fs)) % 65536;
      #1;
      check("model_sout", int'($signed(bus.sout)), exp_s);
      check("model_led", int'(bus.led), exp_l);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_in(input int w_i, input int f_i, input int p_i, input int a_i);
    wt  = 2'(w_i);
    fs  = 3'(f_i);
    ps  = 4'(p_i);
    amp = 4'(a_i);
  endtask

  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Reset, apply inputs, release and return just after the first edge.
  task automatic first_edge(input int w_i, input int f_i, input int p_i, input int a_i);
    @(negedge clk);
    rst_n = 1'b0;
    set_in(w_i, f_i, p_i, a_i);
    @(negedge clk);
    rst_n = 1'b1;
    wait_edges(1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    tests = 0;
    fails = 0;
    acc_m = 0;
    rst_n = 1'b0;
    set_in(1, 7, 0, 15);
    repeat (3) @(posedge clk);
    #2;
    check("reset_sout", int'($signed(bus.sout)), 0);
    check("reset_led", int'(bus.led), 0);

    // Square, 512-cycle period
    @(negedge clk);
    rst_n = 1'b1;
    wait_edges(1);
    check("sq_edge1", int'($signed(bus.sout)), 30719);
    check("sq_led", int'(bus.led), 1);
    wait_edges(255);
    check("sq_edge256", int'($signed(bus.sout)), 30719);
    wait_edges(1);
    check("sq_edge257", int'($signed(bus.sout)), -30720);
    wait_edges(255);
    check("sq_edge512", int'($signed(bus.sout)), -30720);
    wait_edges(1);
    check("sq_edge513", int'($signed(bus.sout)), 30719);

    // First-edge values for each wave
    first_edge(3, 0, 4, 15);
    check("saw_ps4", int'($signed(bus.sout)), -15360);
    first_edge(3, 0, 8, 15);
    check("saw_ps8", int'($signed(bus.sout)), 0);
    first_edge(2, 0, 0, 15);
    check("tri_ps0", int'($signed(bus.sout)), -30720);
    first_edge(0, 0, 4, 15);
`ifdef DSG_SINE_LUT_EN
    check("sine_ps4", int'($signed(bus.sout)), 30719);
`else
    check("sine_ps4", int'($signed(bus.sout)), 0);
`endif
    first_edge(0, 0, 0, 15);
`ifdef DSG_SINE_LUT_EN
    check("sine_ps0", int'($signed(bus.sout)), 0);
`else
    check("sine_ps0", int'($signed(bus.sout)), -30720);
`endif

    // Silence with zero amplitude
    first_edge(3, 5, 3, 0);
    for (int i = 0; i < 40; i++) begin
      check("amp0_sout", int'($signed(bus.sout)), 0);
      check("amp0_led", int'(bus.led), 0);
      @(negedge clk);
      set_in($urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 15), 0);
      wait_edges(1);
    end

    // Asynchronous reset mid-waveform
    @(negedge clk);
    set_in(1, 7, 0, 15);
    wait_edges(37);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_rst_sout", int'($signed(bus.sout)), 0);
    check("async_rst_led", int'(bus.led), 0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_edges(1);
    check("post_rst_edge1", int'($signed(bus.sout)), 30719);

    // Freqsel 0 -> 7 at a random cycle, phase continuous
    first_edge(3, 0, 0, 15);
    n = $urandom_range(5, 60);
    wait_edges(n);
    @(negedge clk);
    fs = 3'd7;
    wait_edges(4);

    // Random inputs held for random spans
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      set_in($urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 15), $urandom_range(0, 15));
      wait_edges($urandom_range(1, 20));
    end

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/digital_signal_generator.md
DIGITAL_SIGNAL_GENERATOR -- requirements
Module: digital_signal_generator

Interface
REQ-001 SHALL have one clock and one reset; reset is asynchronous and active-low.
REQ-002 Clk  input  1  system clock; all state changes on its rising edge.
REQ-003 Rst  input  1  asynchronous active-low reset (0 = reset).
REQ-004 Wavetype  input  2  00 sine, 01 square, 10 triangle, 11 sawtooth.
REQ-005 Freqsel  input  3  frequency select n; phase increment = 1<<n.
REQ-006 Phaseshift  input  4  phase offset in 1/16-cycle steps (offset = Phaseshift<<12).
REQ-007 Amplitude  input  4  gain numerator; gain = Amplitude/16; 0 gives silence.
REQ-008 Sout  output  16  two's-complement sample, registered.
REQ-009 Led  output  1  activity indicator, registered.

Function
REQ-010 SHALL hold a 16-bit phase accumulator acc; each edge acc <= acc + (1<<Freqsel), mod 2^16 (wraps silently); period = 65536>>Freqsel cycles.
REQ-011 SHALL form p = acc + {Phaseshift,12'h000} mod 2^16, combinationally from the current (pre-update) acc.
REQ-012 Square: w = +32767 if p[15]==0, else -32767.
REQ-013 Sawtooth: w = p - 32768 as signed, i.e. {~p[15],p[14:0]}; range -32768..32767.
REQ-014 Triangle: t = p[15] ? ~p[14:0] : p[14:0]; w = {t,1'b0} - 32768; range -32768..32766.
REQ-015 Sine: w = round(32767*sin(2*pi*p/65536)) from a 256-entry quarter-wave magnitude table indexed by p[13:6] (mirrored when p[14]=1), negated when p[15]=1; p[5:0] ignored; table entry 0 = 0, peak = 32767.
REQ-016 Scaling: Sout <= (w * Amplitude) >>> 4, signed 21-bit product, arithmetic shift (floor), truncated to 16 bits; never overflows.
REQ-017 Latency: Sout at edge k reflects acc before edge k and inputs sampled at edge k; one cycle from any input change to Sout.
REQ-018 Input changes SHALL NOT reset acc; frequency/wave changes are phase-continuous.
REQ-019 Led <= 1 when Amplitude != 0, else 0 (registered, one-cycle latency).

Reset
REQ-020 While Rst=0: acc=0, Sout=16'h0000, Led=0, asynchronously, including mid-operation.
REQ-021 First edge after Rst deasserts SHALL produce Sout from acc=0, then advance acc.

Configuration
REQ-022 Macro DSG_SINE_LUT_EN defined: sine table compiled in, Wavetype 00 = sine per REQ-015.
REQ-023 Macro DSG_SINE_LUT_EN undefined: no table; Wavetype 00 SHALL produce the triangle of REQ-014.

Structure
REQ-024 Shared package dsg_pkg SHALL hold the wavetype enum (SINE, SQUARE, TRIANGLE, SAWTOOTH), PHASE_W=16, OUT_W=16, AMP_W=4, LUT_DEPTH=256.
REQ-025 One sub-module dsg_sine_lut (combinational quarter-wave table, 8-bit index -> 15-bit magnitude), instantiated only under DSG_SINE_LUT_EN.

Verification
REQ-026 Square, Freqsel=7, Phaseshift=0, Amplitude=15, release reset -> first edge Sout=30719 (0x77FF); edge 257 onward Sout=-30720 (0x8800); period 512 cycles; Led=1.
REQ-027 Sawtooth, Amplitude=15, Phaseshift=4, first edge -> Sout=-15360; Phaseshift=8 -> Sout=0.
REQ-028 Triangle, Phaseshift=0, Amplitude=15, first edge -> Sout=-30720; Sine with Phaseshift=4 -> Sout=30719; Phaseshift=0 -> Sout=0.
REQ-029 Any wave, Amplitude=0 -> Sout=0 every cycle, Led=0.
REQ-030 Rst driven low mid-waveform (between edges) -> Sout=0 and Led=0 immediately; after release, waveform restarts from acc=0.
REQ-031 Freqsel 0->7 at arbitrary cycle -> acc continues from current value (no phase jump), increment becomes 128 next edge.
